// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types for the store unit
// Purpose: access-size enum, FSM state enum and a size-to-bytes helper used by
//          core_store_unit and core_store_align.
// Ports:   none (package).
package core_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } state_e;

  // Number of bytes touched by an access of the given size (1, 2, 4 or 8).
  function automatic logic [3:0] size_bytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/core_store_align.sv
// rtl/core_store_align.sv - lane shift and strobe generation for one store
// Purpose: turns a right-aligned store (size, byte address, data) into a
//          two-beat window of 2*NB bytes: the low half is beat0, the high
//          half is beat1. Purely combinational.
// Ports:   size_i        access size
//          addr_i        byte address
//          data_i        right-aligned register data
//          beat0_addr_o  addr rounded down to NB
//          beat1_addr_o  beat0_addr_o + NB
//          data_lo_o/hi  lane-positioned data, unused lanes zero
//          strb_lo_o/hi  byte enables for beat0 / beat1
//          misaligned_o  offset not a multiple of the access size
module core_store_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  size_e             size_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   data_i,
  output logic [XLEN-1:0]   beat0_addr_o,
  output logic [XLEN-1:0]   beat1_addr_o,
  output logic [XLEN-1:0]   data_lo_o,
  output logic [XLEN-1:0]   data_hi_o,
  output logic [XLEN/8-1:0] strb_lo_o,
  output logic [XLEN/8-1:0] strb_hi_o,
  output logic              misaligned_o
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  logic [OW-1:0]     off;
  logic [3:0]        off4;
  logic [3:0]        nbytes;
  logic [2*XLEN-1:0] shifted;
  logic [2*NB-1:0]   strb_full;
  logic [2*XLEN-1:0] data_full;

  assign off          = addr_i[OW-1:0];
  assign off4         = 4'(off);
  assign nbytes       = size_bytes(size_i);
  assign misaligned_o = |(off4 & (nbytes - 4'd1));

  assign shifted = {{XLEN{1'b0}}, data_i} << {off, 3'b000};

  // Strobe covers bytes [off, off+nbytes); lanes outside it are forced to
  // zero so stale upper register bits never reach the bus.
  always_comb begin
    strb_full = '0;
    data_full = '0;
    for (int i = 0; i < 2 * NB; i++) begin
      strb_full[i]        = (i >= int'(off)) && (i < int'(off) + int'(nbytes));
      data_full[8*i +: 8] = strb_full[i] ? shifted[8*i +: 8] : 8'h00;
    end
  end

  assign strb_lo_o    = strb_full[NB-1:0];
  assign strb_hi_o    = strb_full[2*NB-1:NB];
  assign data_lo_o    = data_full[XLEN-1:0];
  assign data_hi_o    = data_full[2*XLEN-1:XLEN];
  assign beat0_addr_o = {addr_i[XLEN-1:OW], {OW{1'b0}}};
  assign beat1_addr_o = beat0_addr_o + XLEN'(NB);

endmodule

// File: rtl/core_store_unit.sv
// rtl/core_store_unit.sv - store unit issuing one or two aligned bus beats
// Purpose: accepts a store request, positions data/strobes on the XLEN bus
//          and issues beat0 (and beat1 for a split access), then pulses done.
//          Illegal requests pulse fault without touching the bus.
// Config:  CORE_STORE_MISALIGNED_EN - when defined, misaligned accesses are
//          split over two beats; otherwise they are rejected with fault.
// Ports:   clk, rst_n                 clock, async active-low reset
//          req_valid/req_ready        request handshake (ready only in IDLE)
//          req_size/req_addr/req_data request fields
//          bus_valid/bus_ready        bus beat handshake
//          bus_addr/bus_data/bus_strb beat address, lane data, byte enables
//          done                       one-cycle pulse after the final beat
//          fault                      one-cycle pulse for a rejected request
module core_store_unit
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_data,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_data,
  output logic [XLEN/8-1:0] bus_strb,
  output logic              done,
  output logic              fault
);

  localparam int NB = XLEN / 8;

`ifdef CORE_STORE_MISALIGNED_EN
  localparam bit MISALIGNED_EN = 1'b1;
`else
  localparam bit MISALIGNED_EN = 1'b0;
`endif

  state_e          state_q;
  logic            bus_valid_q;
  logic [XLEN-1:0] bus_addr_q;
  logic [XLEN-1:0] bus_data_q;
  logic [NB-1:0]   bus_strb_q;
  logic [XLEN-1:0] hi_addr_q;
  logic [XLEN-1:0] hi_data_q;
  logic [NB-1:0]   hi_strb_q;
  logic            done_q;
  logic            fault_q;

  size_e           req_sz;
  logic [XLEN-1:0] beat0_addr_d;
  logic [XLEN-1:0] beat1_addr_d;
  logic [XLEN-1:0] data_lo_d;
  logic [XLEN-1:0] data_hi_d;
  logic [NB-1:0]   strb_lo_d;
  logic [NB-1:0]   strb_hi_d;
  logic            misaligned;
  logic            reject;

  assign req_sz = size_e'(req_size);

  core_store_align #(.XLEN(XLEN)) u_align (
    .size_i       (req_sz),
    .addr_i       (req_addr),
    .data_i       (req_data),
    .beat0_addr_o (beat0_addr_d),
    .beat1_addr_o (beat1_addr_d),
    .data_lo_o    (data_lo_d),
    .data_hi_o    (data_hi_d),
    .strb_lo_o    (strb_lo_d),
    .strb_hi_o    (strb_hi_d),
    .misaligned_o (misaligned)
  );

  // A dword cannot be stored on a 32-bit data path; misaligned accesses are
  // only legal when splitting is built in.
  assign reject = ((XLEN == 32) && (req_sz == SZ_D)) || (misaligned && !MISALIGNED_EN);

  // Aligned accesses never set a high-half strobe, so BEAT1 is reachable
  // only when splitting is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      bus_strb_q  <= '0;
      hi_addr_q   <= '0;
      hi_data_q   <= '0;
      hi_strb_q   <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (reject) begin
              fault_q <= 1'b1;
            end else begin
              state_q     <= BEAT0;
              bus_valid_q <= 1'b1;
              bus_addr_q  <= beat0_addr_d;
              bus_data_q  <= data_lo_d;
              bus_strb_q  <= strb_lo_d;
              hi_addr_q   <= beat1_addr_d;
              hi_data_q   <= data_hi_d;
              hi_strb_q   <= strb_hi_d;
            end
          end
        end
        BEAT0: begin
          if (bus_ready) begin
            if (|hi_strb_q) begin
              state_q    <= BEAT1;
              bus_addr_q <= hi_addr_q;
              bus_data_q <= hi_data_q;
              bus_strb_q <= hi_strb_q;
            end else begin
              state_q     <= IDLE;
              bus_valid_q <= 1'b0;
              bus_addr_q  <= '0;
              bus_data_q  <= '0;
              bus_strb_q  <= '0;
              done_q      <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (bus_ready) begin
            state_q     <= IDLE;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            bus_strb_q  <= '0;
            done_q      <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign bus_valid = bus_valid_q;
  assign bus_addr  = bus_addr_q;
  assign bus_data  = bus_data_q;
  assign bus_strb  = bus_strb_q;
  assign done      = done_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_core_store_unit.sv
// tb/tb_core_store_unit.sv - scoreboard bench for core_store_unit (XLEN=32)
module tb_core_store_unit;

  localparam int XLEN = 32;
`ifdef CORE_STORE_MISALIGNED_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        bus_ready = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic        req_ready, bus_valid, done, fault;
  logic [31:0] bus_addr, bus_data;
  logic [3:0]  bus_strb;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          last;
  } beat_t;

  typedef struct {
    bit is_fault;
    int acc_cyc;
  } ev_t;

  beat_t beat_q[$];
  ev_t   ev_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = -10;
  int last_done = -10;
  int prev_done = -10;
  bit br_rand = 1'b0;
  bit br_force = 1'b1;

  core_store_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .bus_strb  (bus_strb),
    .done      (done),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: walk the touched bytes one at a time and drop each into the
  // XLEN/8-aligned word that contains its byte address.
  task automatic model_push(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int          nb;
    bit          mis;
    beat_t       b0, b1;
    logic [31:0] ba;
    int          lane;
    nb  = 1 << sz;
    mis = (int'(a[1:0]) % nb) != 0;
    if (sz == 2'd3 || (mis && !MIS_EN)) begin
      ev_q.push_back('{1'b1, cyc});
      return;
    end
    b0 = '{a & ~32'h3, 32'h0, 4'h0, 1'b0};
    b1 = '{(a & ~32'h3) + 32'd4, 32'h0, 4'h0, 1'b0};
    for (int k = 0; k < nb; k++) begin
      ba   = a + 32'(k);
      lane = int'(ba[1:0]);
      if ((ba & ~32'h3) == b0.addr) begin
        b0.strb[lane]        = 1'b1;
        b0.data[8*lane +: 8] = d[8*k +: 8];
      end else begin
        b1.strb[lane]        = 1'b1;
        b1.data[8*lane +: 8] = d[8*k +: 8];
      end
    end
    if (b1.strb == 4'h0) begin
      b0.last = 1'b1;
      beat_q.push_back(b0);
    end else begin
      b1.last = 1'b1;
      beat_q.push_back(b0);
      beat_q.push_back(b1);
    end
    ev_q.push_back('{1'b0, cyc});
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every beat
  // handshake and every done/fault pulse.
  initial begin
    bit          stall;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_strb;
    beat_t       b;
    ev_t         e;
    int          exp_cyc;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      if (stall && bus_valid) begin
        checks++;
        if (bus_addr !== s_addr || bus_data !== s_data || bus_strb !== s_strb) begin
          errors++;
          $display("FAIL stall_stable: got %h/%h/%b held %h/%h/%b", bus_addr, bus_data, bus_strb, s_addr, s_data, s_strb);
        end
      end
      stall  = bus_valid && !bus_ready;
      s_addr = bus_addr;
      s_data = bus_data;
      s_strb = bus_strb;
      if (bus_valid && bus_ready) begin
        checks++;
        if (beat_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: addr %h data %h strb %b", bus_addr, bus_data, bus_strb);
        end else begin
          b = beat_q.pop_front();
          if (bus_addr !== b.addr || bus_data !== b.data || bus_strb !== b.strb) begin
            errors++;
            $display("FAIL beat: got %h/%h/%b expected %h/%h/%b", bus_addr, bus_data, bus_strb, b.addr, b.data, b.strb);
          end
          if (b.last) hs_cyc = cyc;
        end
      end
      if (done || fault) begin
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: done=%0b fault=%0b with none expected", done, fault);
        end else begin
          e = ev_q.pop_front();
          exp_cyc = e.is_fault ? e.acc_cyc + 1 : hs_cyc + 1;
          if (fault !== e.is_fault || done !== !e.is_fault || cyc != exp_cyc) begin
            errors++;
            $display("FAIL event: got done=%0b fault=%0b at cycle %0d expected fault=%0b at cycle %0d",
                     done, fault, cyc, e.is_fault, exp_cyc);
          end
          if (done) begin
            prev_done = last_done;
            last_done = cyc;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    bus_ready = br_rand ? ($urandom_range(0, 3) != 0) : br_force;
  endtask

  // Presents a request in a cycle where req_ready is seen, so it is taken
  // on the next rising edge.
  task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input bit use_model);
    int n;
    n = 0;
    tick();
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, n);
      return;
    end
    req_valid = 1'b1;
    req_size  = sz;
    req_addr  = a;
    req_data  = d;
    if (use_model) model_push(sz, a, d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((beat_q.size() != 0 || ev_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    tick();
    tick();
    checks++;
    if (beat_q.size() != 0 || ev_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats and %0d events outstanding, required 0", beat_q.size(), ev_q.size());
    end
  endtask

  initial begin
    int          vcnt;
    logic [1:0]  rsz;
    logic [31:0] raddr, rdata;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bus_valid", 64'(bus_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_bus_addr", 64'(bus_addr), 64'd0);
    chk("rst_bus_data", 64'(bus_data), 64'd0);
    chk("rst_bus_strb", 64'(bus_strb), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);

    // Directed single stores with the bus always ready.
    br_force = 1'b1;
    send(2'd2, 32'h100, 32'hDEADBEEF, 1'b1);
    drain();
    send(2'd0, 32'h103, 32'h000000AB, 1'b1);
    drain();
    send(2'd0, 32'h103, 32'h123456AB, 1'b1);
    drain();
    send(2'd2, 32'h102, 32'h11223344, 1'b1);
    drain();
    send(2'd3, 32'h100, 32'h01020304, 1'b1);
    drain();

    // Back-to-back aligned stores: one every 2 cycles.
    for (int i = 0; i < 4; i++) send(2'd2, 32'h300 + 32'(4 * i), 32'hA5A50000 + 32'(i), 1'b1);
    drain();
    chk("tput_aligned", 64'(last_done - prev_done), 64'd2);

`ifdef CORE_STORE_MISALIGNED_EN
    // Back-to-back split stores: one every 3 cycles.
    for (int i = 0; i < 4; i++) send(2'd2, 32'h401 + 32'(4 * i), 32'h5A5A0000 + 32'(i), 1'b1);
    drain();
    chk("tput_split", 64'(last_done - prev_done), 64'd3);
`endif

    // Halfword held off by bus_ready=0 for three cycles.
    br_force = 1'b0;
    send(2'd1, 32'h104, 32'h0000BEEF, 1'b1);
    vcnt = 0;
    repeat (3) begin
      tick();
      vcnt += int'(bus_valid);
    end
    br_force = 1'b1;
    tick();
    vcnt += int'(bus_valid);
    tick();
    chk("stall_valid_cycles", 64'(vcnt), 64'd4);
    chk("stall_done", 64'(done), 64'd1);
    chk("stall_valid_after", 64'(bus_valid), 64'd0);
    drain();

    // Reset while a store is on the bus: it must be abandoned silently.
`ifdef CORE_STORE_MISALIGNED_EN
    br_force = 1'b1;
    beat_q.push_back('{32'h100, 32'h33440000, 4'hC, 1'b0});
    send(2'd2, 32'h102, 32'h11223344, 1'b0);
    tick();
    tick();
    chk("mid_beat1_valid", 64'(bus_valid), 64'd1);
    chk("mid_beat1_addr", 64'(bus_addr), 64'h104);
`else
    br_force = 1'b0;
    send(2'd2, 32'h100, 32'h11223344, 1'b0);
    tick();
    chk("mid_beat0_valid", 64'(bus_valid), 64'd1);
`endif
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus_valid), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    br_force = 1'b1;
    repeat (5) tick();
    drain();
    send(2'd2, 32'h200, 32'hCAFEF00D, 1'b1);
    drain();

    // Randomised traffic with a randomly stalling bus.
    br_rand = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) != 0) begin
        rsz   = 2'($urandom_range(0, 3));
        raddr = 32'h2000 + 32'($urandom_range(0, 31));
        rdata = $urandom;
        send(rsz, raddr, rdata, 1'b1);
      end else begin
        tick();
      end
    end
    drain();
    br_rand = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_store_unit.md
CORE_STORE_UNIT -- requirements
Module: core_store_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, the data-path width; only 32 and 64 are legal.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-003 The module SHALL have port rst_n, input, 1 bit, the reset; reset is asynchronous and active-low.
REQ-004 The module SHALL have port req_valid, input, 1 bit, store request valid.
REQ-005 The module SHALL have port req_ready, output, 1 bit, unit idle and able to accept a request.
REQ-006 The module SHALL have port req_size, input, 2 bits, access size: 00 byte, 01 half, 10 word, 11 dword.
REQ-007 The module SHALL have port req_addr, input, XLEN bits, byte address.
REQ-008 The module SHALL have port req_data, input, XLEN bits, register data, right-aligned.
REQ-009 The module SHALL have port bus_valid, output, 1 bit, bus beat valid.
REQ-010 The module SHALL have port bus_ready, input, 1 bit, bus beat accepted.
REQ-011 The module SHALL have port bus_addr, output, XLEN bits, beat address aligned to XLEN/8.
REQ-012 The module SHALL have port bus_data, output, XLEN bits, lane-positioned write data.
REQ-013 The module SHALL have port bus_strb, output, XLEN/8 bits, byte write enables.
REQ-014 The module SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-015 The module SHALL have port fault, output, 1 bit, one-cycle pulse for a rejected request.

Function
REQ-016 The FSM SHALL have states IDLE, BEAT0 and BEAT1; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on req_valid && req_ready; the unit SHALL latch size, address and data, and go to BEAT0.
REQ-018 With NB = XLEN/8 and off = addr mod NB, the unit SHALL form a 2*NB-byte strobe ((1<<bytes)-1)<<off and data req_data<<(8*off); the low half is beat0, the high half is beat1.
REQ-019 Beat0 SHALL use bus_addr = addr & ~(NB-1); beat1 SHALL use beat0 address + NB.
REQ-020 Byte lanes whose strobe is 0 SHALL be driven 0 on bus_data.
REQ-021 While bus_valid=1 and bus_ready=0, bus_addr, bus_data and bus_strb SHALL hold stable.
REQ-022 On the beat0 handshake the FSM SHALL go to BEAT1 if the high-half strobe is non-zero, else to IDLE.
REQ-023 On the beat1 handshake the FSM SHALL go to IDLE.
REQ-024 done SHALL pulse in the cycle after the final beat handshake; req_ready is 1 in that same cycle.
REQ-025 A request with req_size=11 when XLEN=32 SHALL raise fault for one cycle after acceptance, with no bus beat and no done.
REQ-026 With bus_ready held at 1, sustained throughput SHALL be one store per 2 cycles for aligned requests and one per 3 cycles for split requests.

Reset
REQ-027 While rst_n=0: state SHALL be IDLE; bus_valid, done and fault SHALL be 0; bus_addr, bus_data and bus_strb SHALL be 0; req_ready SHALL be 1 after release.
REQ-028 Reset asserted mid-operation SHALL drop bus_valid immediately and abandon the store, with no done and no fault.

Configuration
REQ-029 With CORE_STORE_MISALIGNED_EN defined, misaligned requests (off not a multiple of the access size) SHALL split across beats per REQ-018 to REQ-023.
REQ-030 Without CORE_STORE_MISALIGNED_EN, a misaligned request SHALL raise fault per REQ-025; BEAT1 is never entered and MAY be removed by synthesis.

Structure
REQ-031 Package core_pkg SHALL hold the size enum (SZ_B, SZ_H, SZ_W, SZ_D) and the FSM state enum.
REQ-032 The combinational shift/strobe generation SHALL live in the sub-module core_store_align, parametrised by XLEN.

Verification (XLEN=32, bus_ready=1 unless stated)
REQ-033 SW, addr 0x100, data 0xDEADBEEF -> one beat: addr 0x100, strb 1111, data 0xDEADBEEF; done pulses 1 cycle later.
REQ-034 SB, addr 0x103, data 0x000000AB -> one beat: addr 0x100, strb 1000, data 0xAB000000.
REQ-035 SW, addr 0x102, data 0x11223344, macro defined -> beat0: 0x100, strb 1100, data 0x33440000; beat1: 0x104, strb 0011, data 0x00001122; a single done.
REQ-036 Same as REQ-035 with macro undefined -> fault pulse, bus_valid never 1, no done.
REQ-037 SH, addr 0x104, with bus_ready=0 for 3 cycles -> bus outputs stable for 4 cycles; done after the handshake.
REQ-038 rst_n low during BEAT1 of REQ-035 -> bus_valid 0 in the same cycle; no done; req_ready=1 after release.
